// File: rtl/ft245_device_emulator.sv
// ft245_device_emulator: device end of an FT245-style asynchronous FIFO bus.
// A host-to-controller queue is presented on RXF/RD/D, a controller-to-host
// queue is accepted on TXE/WR/D, and a valid/ready host stream fills and
// drains the two queues. Every output comes straight from a register.
module ft245_device_emulator #(
    parameter int DEPTH          = 16,
    parameter int RECOVER_CYCLES = 2
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    inout  wire  [7:0]               D,
    input  logic                     RD,
    input  logic                     WR,
    output logic                     RXF,
    output logic                     TXE,
    input  logic [7:0]               H_TX_DATA,
    input  logic                     H_TX_VALID,
    output logic                     H_TX_READY,
    output logic [7:0]               H_RX_DATA,
    output logic                     H_RX_VALID,
    input  logic                     H_RX_READY,
    output logic [$clog2(DEPTH):0]   RX_LEVEL,
    output logic [$clog2(DEPTH):0]   TX_LEVEL,
    output logic                     PROTO_ERR
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int CW = (RECOVER_CYCLES > 1) ? $clog2(RECOVER_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(RECOVER_CYCLES - 1);
    localparam logic [LW-1:0] FULL     = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        READ_ACTIVE,
        WRITE_ACTIVE,
        RECOVER
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rxf_q, rxf_d;
    logic            txe_q, txe_d;
    logic            drive_q, drive_d;
    logic [7:0]      dout_q, dout_d;
    logic [7:0]      wbyte_q, wbyte_d;
    logic            err_q, err_d;

    logic [7:0]      rx_mem [DEPTH];
    logic [7:0]      tx_mem [DEPTH];
    logic [PW-1:0]   rx_wptr_q, rx_wptr_d, rx_rptr_q, rx_rptr_d;
    logic [PW-1:0]   tx_wptr_q, tx_wptr_d, tx_rptr_q, tx_rptr_d;
    logic [LW-1:0]   rx_level_q, rx_level_d, tx_level_q, tx_level_d;

    logic            htx_ready_q, htx_ready_d;
    logic            hrx_valid_q, hrx_valid_d;
    logic [7:0]      hrx_data_q, hrx_data_d;

    logic            host_push, host_pop, ctrl_pop, ctrl_push;
    logic            rd_ok, wr_ok;

    // Bus FSM next state, strobe decoding and protocol-violation detection.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        drive_d   = drive_q;
        dout_d    = dout_q;
        wbyte_d   = wbyte_q;
        err_d     = err_q;
        rxf_d     = rxf_q;
        txe_d     = txe_q;
        ctrl_pop  = 1'b0;
        ctrl_push = 1'b0;
        rd_ok     = !RD && !rxf_q;
        wr_ok     = !WR && !txe_q;

        case (state_q)
            IDLE: begin
                if (rd_ok) begin
                    // Read wins any collision; a concurrent WR is a violation.
                    dout_d  = rx_mem[rx_rptr_q];
                    drive_d = 1'b1;
                    state_d = READ_ACTIVE;
                    if (!WR) err_d = 1'b1;
                end else begin
                    if (!RD) err_d = 1'b1;
                    if (wr_ok) begin
                        wbyte_d = D;
                        state_d = WRITE_ACTIVE;
                    end else if (!WR) begin
                        err_d = 1'b1;
                    end
                end
            end
            READ_ACTIVE: begin
                if (!WR) err_d = 1'b1;
                if (RD) begin
                    ctrl_pop = 1'b1;
                    drive_d  = 1'b0;
                    cnt_d    = CNT_LOAD;
                    state_d  = RECOVER;
                end
            end
            WRITE_ACTIVE: begin
                if (!RD) err_d = 1'b1;
                if (!WR) begin
                    wbyte_d = D;
                end else begin
                    ctrl_push = 1'b1;
                    cnt_d     = CNT_LOAD;
                    state_d   = RECOVER;
                end
            end
            RECOVER: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // Flags follow the registered levels while idle, so they trail a
        // level change by one cycle; active strobes hold their flag low.
        case (state_d)
            IDLE: begin
                rxf_d = (rx_level_q == '0);
                txe_d = (tx_level_q == FULL);
            end
            RECOVER: begin
                rxf_d = 1'b1;
                txe_d = 1'b1;
            end
            default: ;
        endcase
    end

    // Queue pointer/level arithmetic and registered host-side view.
    always_comb begin
        host_push  = H_TX_VALID && htx_ready_q;
        host_pop   = H_RX_READY && hrx_valid_q;

        rx_wptr_d  = rx_wptr_q + PW'(host_push);
        rx_rptr_d  = rx_rptr_q + PW'(ctrl_pop);
        rx_level_d = rx_level_q + LW'(host_push) - LW'(ctrl_pop);

        tx_wptr_d  = tx_wptr_q + PW'(ctrl_push);
        tx_rptr_d  = tx_rptr_q + PW'(host_pop);
        tx_level_d = tx_level_q + LW'(ctrl_push) - LW'(host_pop);

        htx_ready_d = (rx_level_d != FULL);
        hrx_valid_d = (tx_level_d != '0);
        // The new head may be the byte being written this very cycle.
        if (ctrl_push && (tx_wptr_q == tx_rptr_d)) hrx_data_d = wbyte_q;
        else                                       hrx_data_d = tx_mem[tx_rptr_d];
    end

    // State, flag, pointer and output registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rxf_q       <= 1'b1;
            txe_q       <= 1'b1;
            drive_q     <= 1'b0;
            dout_q      <= '0;
            wbyte_q     <= '0;
            err_q       <= 1'b0;
            rx_wptr_q   <= '0;
            rx_rptr_q   <= '0;
            rx_level_q  <= '0;
            tx_wptr_q   <= '0;
            tx_rptr_q   <= '0;
            tx_level_q  <= '0;
            htx_ready_q <= 1'b0;
            hrx_valid_q <= 1'b0;
            hrx_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rxf_q       <= rxf_d;
            txe_q       <= txe_d;
            drive_q     <= drive_d;
            dout_q      <= dout_d;
            wbyte_q     <= wbyte_d;
            err_q       <= err_d;
            rx_wptr_q   <= rx_wptr_d;
            rx_rptr_q   <= rx_rptr_d;
            rx_level_q  <= rx_level_d;
            tx_wptr_q   <= tx_wptr_d;
            tx_rptr_q   <= tx_rptr_d;
            tx_level_q  <= tx_level_d;
            htx_ready_q <= htx_ready_d;
            hrx_valid_q <= hrx_valid_d;
            hrx_data_q  <= hrx_data_d;
        end
    end

    // Queue storage writes; contents are not cleared, pointers define validity.
    always_ff @(posedge CLK) begin
        if (RST_N) begin
            if (host_push) rx_mem[rx_wptr_q] <= H_TX_DATA;
            if (ctrl_push) tx_mem[tx_wptr_q] <= wbyte_q;
        end
    end

    assign D          = drive_q ? dout_q : 'z;
    assign RXF        = rxf_q;
    assign TXE        = txe_q;
    assign H_TX_READY = htx_ready_q;
    assign H_RX_DATA  = hrx_data_q;
    assign H_RX_VALID = hrx_valid_q;
    assign RX_LEVEL   = rx_level_q;
    assign TX_LEVEL   = tx_level_q;
    assign PROTO_ERR  = err_q;

endmodule

// File: doc/ft245_device_emulator.md
Name: ft245_device_emulator

Overview:
- Synthesizable model of the FTDI FT245-style asynchronous FIFO chip: the device end of the D/RXF/TXE/RD/WR interface that mod_controller drives.
- Holds a host-to-controller byte queue (presented via RXF/RD) and a controller-to-host byte queue (accepted via TXE/WR).
- A simple valid/ready host-side stream fills and drains the queues.
- Used in the on-chip loopback/self-test build and as the bus-accurate partner in controller benches.

Parameters:
- DEPTH, 16, entries per queue; power of two, at least 2.
- RECOVER_CYCLES, 2, cycles RXF/TXE are held high after each completed strobe; at least 1.

Ports:
- CLK  in  1  system clock; all logic on posedge.
- RST_N  in  1  synchronous, active-low reset.
- D  inout  8  shared data bus; driven only in READ_ACTIVE, else high-Z.
- RD  in  1  active-low read strobe from controller.
- WR  in  1  active-low write strobe from controller.
- RXF  out  1  active-low: byte available for controller to read.
- TXE  out  1  active-low: space available for controller to write.
- H_TX_DATA  in  8  host byte to queue for the controller.
- H_TX_VALID  in  1  host push request.
- H_TX_READY  out  1  host-to-controller queue not full.
- H_RX_DATA  out  8  head of controller-to-host queue.
- H_RX_VALID  out  1  controller-to-host queue non-empty.
- H_RX_READY  in  1  host pop.
- RX_LEVEL  out  $clog2(DEPTH)+1  host-to-controller occupancy.
- TX_LEVEL  out  $clog2(DEPTH)+1  controller-to-host occupancy.
- PROTO_ERR  out  1  sticky protocol-violation flag; cleared only by reset.

Behaviour:
- Reset (RST_N=0 at posedge): both queues empty, pointers 0, state IDLE, RXF=1, TXE=1, D high-Z, H_TX_READY=0, H_RX_VALID=0, levels 0, PROTO_ERR=0. A reset mid-strobe aborts the transfer and discards queue contents; the D driver is released at that same edge.
- RD and WR are sampled at posedge. All outputs are registered.
- States:
  - IDLE.
  - READ_ACTIVE.
  - WRITE_ACTIVE.
  - RECOVER: counter loaded with RECOVER_CYCLES-1.
- IDLE:
  - RXF=0 iff RX_LEVEL>0.
  - TXE=0 iff TX_LEVEL<DEPTH.
  - Each takes effect 1 cycle after the level change.
- IDLE, RD=0 and RXF=0: latch head byte into the output register, enter READ_ACTIVE. D is driven from the next cycle.
- READ_ACTIVE:
  - D is driven with the latched byte while RD stays 0.
  - On RD=1: pop the head, release D, set RXF=1, enter RECOVER.
- IDLE, WR=0 and TXE=0 (and not RD=0 with RXF=0): enter WRITE_ACTIVE, capture D.
- WRITE_ACTIVE:
  - Re-capture D every cycle WR=0.
  - On WR=1: push the last captured byte, set TXE=1, enter RECOVER.
- RECOVER: RXF=1 and TXE=1; counts down, then returns to IDLE.
- Simultaneous RD=0 and WR=0 in IDLE with both serviceable: the read wins, the write is ignored, PROTO_ERR is set.
- PROTO_ERR is also set by:
  - RD=0 while RXF=1, or WR=0 while TXE=1, in IDLE;
  - WR=0 during READ_ACTIVE;
  - RD=0 during WRITE_ACTIVE.
  Offending strobes have no queue effect.
- Host side:
  - Push when H_TX_VALID and H_TX_READY.
  - Pop when H_RX_VALID and H_RX_READY.
  - Push and controller-pop in the same cycle are both honoured; the level is unchanged.
  - Same applies to controller-push with host-pop.
  - H_TX_READY=!(RX_LEVEL==DEPTH); H_RX_VALID=(TX_LEVEL!=0).
  - H_RX_DATA is the head byte, stable while H_RX_VALID and not popped.
- Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. Level arithmetic has one extra bit, so full reads exactly DEPTH.
- Pushes into a full queue and pops from an empty queue cannot occur; ready/valid and RXF/TXE gate them.

Test Plan:
- Reset: hold RST_N=0 for 3 cycles, then release.
  - During reset: RXF=1, TXE=1, D=z, H_TX_READY=0, levels 0.
  - One cycle after release: TXE=0, H_TX_READY=1, RXF stays 1.
- Host pushes 0x01, 0x0C, "Hello world!" (14 bytes); controller-side bench performs 14 RD strobes.
  - D returns 0x01, 0x0C, 0x48 … 0x21 in order.
  - RXF=1 for 2 cycles after each strobe.
  - After the 14th strobe, RXF stays 1 and RX_LEVEL=0.
- Controller writes 0xA5 then 0x5A with H_RX_READY=0.
  - TX_LEVEL=2, H_RX_DATA=0xA5.
  - Assert H_RX_READY for 2 cycles: 0xA5 then 0x5A popped, H_RX_VALID=0.
- 16 WR strobes with no host pop.
  - TXE stays 1 after the 16th; TX_LEVEL=16.
  - A 17th WR is ignored and PROTO_ERR=1.
  - One host pop: TXE=0 after RECOVER/IDLE.
- Wrap: 40 bytes streamed through with interleaved host push and controller read → data order preserved across pointer wrap; levels never exceed 16.
- RD=0 and WR=0 asserted together in IDLE with both queues serviceable → read completes with the correct byte, TX_LEVEL unchanged, PROTO_ERR=1.
- Reset asserted during READ_ACTIVE → D high-Z at that edge; queues empty.
